// File: rtl/mem_bist_if.sv
// rtl/mem_bist_if.sv - single-port memory port bundle shared by the BIST initiator and the RAM
interface mem_bist_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  // Initiator side: drives the request, receives registered read data.
  modport master (
    output ren,
    output wen,
    output addr,
    output din,
    input  dout
  );

  // Memory side.
  modport slave (
    input  ren,
    input  wen,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - three-phase march BIST initiator with first-mismatch capture
module mem_bist #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] pattern_i,
  mem_bist_if.master        mem,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_got_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_INV_RD, S_INV_WR, S_VERIFY, S_DRAIN, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [DATA_W-1:0] pattern_q;
  logic              ren_q, wen_q, busy_q, done_q, fail_q;
  logic [ADDR_W-1:0] addr_q, fail_addr_q;
  logic [DATA_W-1:0] din_q, fail_exp_q, fail_got_q;

  logic              cmp_en_d;
  logic [ADDR_W-1:0] cmp_addr_d;
  logic [DATA_W-1:0] cmp_exp_d;
  logic              mismatch_d;
  logic [ADDR_W-1:0] addr_next_d, addr_prev_d;

  // Seed word XOR zero-extended address; each address gets a distinct word.
  function automatic logic [DATA_W-1:0] data_of(input logic [DATA_W-1:0] pat,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = '0;
    ext[ADDR_W-1:0] = a;
    return pat ^ ext;
  endfunction

  // addr_q doubles as the march address counter.
  assign addr_next_d = addr_q + ADDR_ONE;
  assign addr_prev_d = addr_q - ADDR_ONE;

  // Expected word for the read issued one cycle earlier (RAM has one-cycle read latency).
  always_comb begin
    cmp_en_d   = 1'b0;
    cmp_addr_d = addr_q;
    cmp_exp_d  = data_of(pattern_q, addr_q);
    case (state_q)
      S_INV_WR: cmp_en_d = 1'b1;
      S_VERIFY: begin
        cmp_en_d   = (addr_q != '0);
        cmp_addr_d = addr_prev_d;
        cmp_exp_d  = ~data_of(pattern_q, addr_prev_d);
      end
      S_DRAIN: begin
        cmp_en_d  = 1'b1;
        cmp_exp_d = ~data_of(pattern_q, addr_q);
      end
      default: cmp_en_d = 1'b0;
    endcase
  end

  assign mismatch_d = cmp_en_d && (mem.dout != cmp_exp_d);

  // March sequencer; every memory-port output is produced here as a register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort_i) begin
        // Abort releases the port at once and keeps whatever failure was captured.
        state_q <= S_IDLE;
        ren_q   <= 1'b0;
        wen_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (mismatch_d) begin
          fail_q <= 1'b1;
          if (!fail_q) begin
            fail_addr_q <= cmp_addr_d;
            fail_exp_q  <= cmp_exp_d;
            fail_got_q  <= mem.dout;
          end
        end
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              state_q     <= S_FILL;
              pattern_q   <= pattern_i;
              wen_q       <= 1'b1;
              addr_q      <= '0;
              din_q       <= pattern_i;
              busy_q      <= 1'b1;
              fail_q      <= 1'b0;
              fail_addr_q <= '0;
              fail_exp_q  <= '0;
              fail_got_q  <= '0;
            end
          end
          S_FILL: begin
            if (addr_q == ADDR_MAX) begin
              state_q <= S_INV_RD;
              wen_q   <= 1'b0;
              ren_q   <= 1'b1;
            end else begin
              addr_q <= addr_next_d;
              din_q  <= data_of(pattern_q, addr_next_d);
            end
          end
          S_INV_RD: begin
            state_q <= S_INV_WR;
            ren_q   <= 1'b0;
            wen_q   <= 1'b1;
            din_q   <= ~data_of(pattern_q, addr_q);
          end
          S_INV_WR: begin
            wen_q <= 1'b0;
            ren_q <= 1'b1;
            if (addr_q == '0) begin
              state_q <= S_VERIFY;
            end else begin
              state_q <= S_INV_RD;
              addr_q  <= addr_prev_d;
            end
          end
          S_VERIFY: begin
            if (addr_q == ADDR_MAX) begin
              state_q <= S_DRAIN;
              ren_q   <= 1'b0;
            end else begin
              addr_q <= addr_next_d;
            end
          end
          S_DRAIN: begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem.ren     = ren_q;
  assign mem.wen     = wen_q;
  assign mem.addr    = addr_q;
  assign mem.din     = din_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - directed vector bench for mem_bist with a 128x8 RAM model
module tb_mem_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic       busy, done, fail;
  logic [6:0] fail_addr;
  logic [7:0] fail_exp, fail_got;

  int n_vec  = 0;
  int n_miss = 0;
  bit stuck  = 1'b0;

  logic [7:0] ram [128];

  mem_bist_if #(.ADDR_W(7), .DATA_W(8)) mif ();

  mem_bist #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .pattern_i   (pattern),
    .mem         (mif),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_exp_o  (fail_exp),
    .fail_got_o  (fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, read wins over write, optional bit-0 stuck-at-0 at address 15
  always @(posedge clk) begin
    if (mif.ren) mif.dout <= ram[mif.addr];
    else if (mif.wen) ram[mif.addr] <= (stuck && mif.addr == 7'd15) ? (mif.din & 8'hFE) : mif.din;
  end

  typedef struct {
    logic [7:0] pattern;
    bit         stuck;
    bit         repulse;
    bit         exp_fail;
    int         exp_fail_cyc;
    logic [6:0] exp_faddr;
    logic [7:0] exp_fexp;
    logic [7:0] exp_fgot;
    logic [6:0] chk_addr;
    logic [7:0] chk_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int done_cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int fail_cyc = 0;
    int bad = 0;
    bit both = 1'b0;
    logic [7:0] e;
    stuck = v.stuck;
    @(negedge clk);
    pattern = v.pattern;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_first_write"}, 64'({mif.wen, mif.ren, mif.addr, mif.din, busy}),
        64'({1'b1, 1'b0, 7'd0, v.pattern, 1'b1}));
    for (int n = 1; n <= 520; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (fail && fail_cyc == 0) fail_cyc = n;
      if (mif.ren && mif.wen) both = 1'b1;
      start = v.repulse && (n == 10 || n == 300);
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(514));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(513));
    chk({tag, "_ren_wen_both"}, 64'(both), 64'(0));
    chk({tag, "_fail"}, 64'(fail), 64'(v.exp_fail));
    chk({tag, "_fail_cycle"}, 64'(fail_cyc), 64'(v.exp_fail_cyc));
    chk({tag, "_fail_fields"}, 64'({fail_addr, fail_exp, fail_got}),
        64'({v.exp_faddr, v.exp_fexp, v.exp_fgot}));
    chk({tag, "_mem_word"}, 64'(ram[v.chk_addr]), 64'(v.chk_data));
    for (int i = 0; i < 128; i++) begin
      e = ~(v.pattern ^ 8'(i));
      if (v.stuck && i == 15) e = e & 8'hFE;
      if (ram[i] !== e) bad++;
    end
    chk({tag, "_mem_image"}, 64'(bad), 64'(0));
  endtask

  initial begin
    bit seen;
    //           pattern stuck repulse fail cyc  faddr  fexp   fgot   chk_a   chk_d
    vecs[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 0,   7'd0,  8'h00, 8'h00, 7'd15,  8'hF0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 0,   7'd0,  8'h00, 8'h00, 7'd127, 8'h80};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 0,   7'd0,  8'h00, 8'h00, 7'd127, 8'h7F};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 355, 7'd15, 8'h0F, 8'h0E, 7'd15,  8'hF0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0,   7'd0,  8'h00, 8'h00, 7'd3,   8'h59};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 355, 7'd15, 8'h55, 8'h54, 7'd15,  8'hAA};

    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({busy, done, fail, mif.ren, mif.wen, mif.addr, mif.din, fail_addr, fail_exp, fail_got}),
        64'(0));
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // abort during FILL at address 40
    stuck = 1'b0;
    @(negedge clk);
    pattern = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_setup_fill40", 64'({mif.wen, mif.addr}), 64'({1'b1, 7'd40}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_released", 64'({mif.ren, mif.wen, busy, done}), 64'(0));
    seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'(0));
    run_vec(vecs[0], "after_abort");

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    seen  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || mif.wen || mif.ren) seen = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'(seen), 64'(0));

    // reset during VERIFY with a captured failure
    stuck = 1'b1;
    @(negedge clk);
    pattern = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (399) @(negedge clk);
    chk("reset_setup_verify", 64'({fail, mif.ren, mif.addr}), 64'({1'b1, 1'b1, 7'd15}));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run",
        64'({busy, done, fail, mif.ren, mif.wen, mif.addr, mif.din, fail_addr, fail_exp, fail_got}),
        64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test initiator for the 128 x 8 single-port `Memory` block. On `start` it drives the memory's `ren`/`wen`/`addr`/`din` port through a fixed three-phase march sequence and compares every read-back word. It reports `done` and the first mismatch. It sits beside `Memory` and owns its port while `busy`; the system side holds the port when idle.

## Interface

Parameters:
- `ADDR_W`, 7: memory address width; depth = 2^ADDR_W.
- `DATA_W`, 8: memory word width; must be ≥ ADDR_W.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a test run; sampled only in IDLE.
- `abort` input 1: terminate a run; priority over `start`.
- `pattern` input DATA_W: seed word; sampled together with `start`.
- `ren` output 1: memory read enable.
- `wen` output 1: memory write enable.
- `addr` output ADDR_W: memory address.
- `din` output DATA_W: memory write data.
- `dout` input DATA_W: memory read data.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at normal completion.
- `fail` output 1: sticky; a mismatch was seen in the current or last run.
- `fail_addr` output ADDR_W: address of the first mismatch.
- `fail_exp` output DATA_W: expected word at the first mismatch.
- `fail_got` output DATA_W: received word at the first mismatch.

## Operation

Memory contract:
- Read data is registered, one-cycle latency: `dout` is valid in the cycle after the edge that sampled `ren`=1.
- `ren` has priority over `wen`.
- `mem_bist` never asserts `ren` and `wen` together.

Data function:
- D(a) = `pattern_q` XOR zero-extended a.
- `pattern_q` is the register captured at start.

States:
- IDLE: `ren`=`wen`=0, `busy`=0.
  - `start`=1 and `abort`=0 → FILL, with a=0, `pattern_q`=`pattern`.
  - `fail`, `fail_addr`, `fail_exp` and `fail_got` are cleared on this transition.
- FILL: one write per cycle, ascending a=0..127.
  - Drives `wen`=1, `addr`=a, `din`=D(a).
  - After a=127 → INV_RD with a=127.
- INV_RD / INV_WR: two cycles per address, descending a=127..0.
  - INV_RD drives `ren`=1, `addr`=a.
  - INV_WR drives `wen`=1, `addr`=a, `din`=~D(a), and compares `dout` against D(a) in the same cycle.
  - After INV_WR with a=0 → VERIFY with a=0.
- VERIFY: one read per cycle, ascending a=0..127, `ren`=1.
  - The compare for address a-1 happens in the cycle that reads a, against ~D(a-1).
  - After a=127 → DRAIN.
- DRAIN: `ren`=0; compares `dout` against ~D(127) → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.

Compare and fail capture:
- A mismatch sets `fail` at the next edge.
- `fail_addr`/`fail_exp`/`fail_got` are loaded only on the first mismatch of a run.
- The run continues to completion after a mismatch; run length is fixed.

Port ownership:
- `ren`, `wen`, `addr` and `din` come straight from registers.
- No combinational path from `start`, `abort` or `dout` to memory-port outputs.

Boundary conditions:
- `start` while busy: ignored.
- `abort`=1 in any non-IDLE state: → IDLE at the next edge. `ren`=`wen`=0 from then; no `done` pulse; `fail` fields are kept.
- `abort` and `start` both high in IDLE: stay in IDLE.
- `rst_n` low mid-run: immediate IDLE. All outputs go to 0, including the `fail` fields; the memory contents are left partially written.
- Address counters wrap only through the state transitions above, never modulo.

## Timing

- Reset values: every output 0, state IDLE.
- Start latency: `start` sampled at edge E0 → first FILL write is driven in the cycle after E0.
- `busy`:
  - goes high in that same cycle;
  - stays high for exactly 513 cycles: 128 FILL + 256 INV + 128 VERIFY + 1 DRAIN;
  - on its falling cycle, `done` is high for 1 cycle.
- Compare latency: in INV_WR, the compare is on the read issued one cycle earlier. In VERIFY/DRAIN, the compare is on the read issued one cycle earlier.
- `fail` visible 1 cycle after the mismatching compare cycle.
- Earliest re-`start`: the cycle after `done`.

## Test plan

- Fault-free `Memory`, `pattern`=8'h00:
  - `done` exactly 514 cycles after `start` edge;
  - `fail`=0;
  - memory[a]=~a (e.g. mem[15]=8'hF0, mem[127]=8'h80).
- Fault-free, `pattern`=8'hFF: no fail; mem[127]=8'h7F.
- Bench memory with bit 0 of address 15 stuck-at-0, `pattern`=8'h00:
  - first mismatch in INV phase;
  - `fail`=1, `fail_addr`=15, `fail_exp`=8'h0F, `fail_got`=8'h0E;
  - `done` still at cycle 514.
- `abort` pulsed at FILL address 40:
  - next cycle `ren`=`wen`=0, `busy`=0;
  - no `done`;
  - a new `start` runs the full 514 cycles.
- `start` re-pulsed at cycles 10 and 300 of a run: ignored; completion timing unchanged. `start`+`abort` together in IDLE: `busy` stays 0.
- `rst_n` asserted during VERIFY with `fail`=1: all outputs 0 immediately; after release, `start` produces a clean run.
